// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, FSM states and ALU selects for the multicycle MIPS core.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_LUI
  } alu_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_mc_core_if.sv
// Instruction and data memory request/ready bus between the core and its memories.
interface mips_mc_core_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mips_mc_alu.sv
// Combinational ALU shared by address generation, arithmetic and branch compare.
module mips_mc_alu
  import mips_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  alu_sel_e    sel,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  logic signed [31:0] op1_s;
  logic signed [31:0] op2_s;

  assign op1_s = op1;
  assign op2_s = op2;

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_SLT: result = {31'd0, (op1_s < op2_s)};
      ALU_SLL: result = op2 << shamt;
      ALU_LUI: result = {op2[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with internal 32x32 register file.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_INIT      = 32'h0000_0000,
  parameter logic [31:0] SP_INIT      = 32'h0000_0000,
  parameter logic [31:0] RA_INIT      = 32'h0000_0000,
  parameter bit          SKIP_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_mc_core_if.master        bus,
  output logic                  retire,
  output logic                  illegal,
  output logic                  halted,
  output logic [31:0]           pc
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        zero_q, zero_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wr_addr;
  logic [31:0] simm, alu_op2, alu_res, pc_plus4, br_target, j_target;
  logic        alu_zero;
  alu_sel_e    alu_sel;
  logic        use_imm, wr_en, is_load, is_store, is_beq, is_bne, is_j, is_jr, is_ill;

  // Decode is purely a function of the latched instruction, valid from DECODE through WB.
  always_comb begin
    opcode   = ir_q[31:26];
    funct    = ir_q[5:0];
    rs       = ir_q[25:21];
    rt       = ir_q[20:16];
    rd       = ir_q[15:11];
    shamt    = ir_q[10:6];
    simm     = sext16(ir_q[15:0]);
    alu_sel  = ALU_ADD;
    use_imm  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = rd;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    is_ill   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin alu_sel = ALU_ADD; wr_en = 1'b1; end
          FN_SUBU: begin alu_sel = ALU_SUB; wr_en = 1'b1; end
          FN_AND:  begin alu_sel = ALU_AND; wr_en = 1'b1; end
          FN_OR:   begin alu_sel = ALU_OR;  wr_en = 1'b1; end
          FN_SLT:  begin alu_sel = ALU_SLT; wr_en = 1'b1; end
          FN_SLL:  begin alu_sel = ALU_SLL; wr_en = 1'b1; end
          FN_JR:   is_jr = 1'b1;
          default: is_ill = 1'b1;
        endcase
      end
      OP_ADDIU: begin use_imm = 1'b1; wr_en = 1'b1; wr_addr = rt; end
      OP_LUI:   begin alu_sel = ALU_LUI; use_imm = 1'b1; wr_en = 1'b1; wr_addr = rt; end
      OP_LW:    begin use_imm = 1'b1; is_load = 1'b1; wr_en = 1'b1; wr_addr = rt; end
      OP_SW:    begin use_imm = 1'b1; is_store = 1'b1; end
      OP_BEQ:   begin alu_sel = ALU_SUB; is_beq = 1'b1; end
      OP_BNE:   begin alu_sel = ALU_SUB; is_bne = 1'b1; end
      OP_J:     is_j = 1'b1;
      default:  is_ill = 1'b1;
    endcase
  end

  assign alu_op2   = use_imm ? simm : b_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {simm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  mips_mc_alu u_alu (
    .op1    (a_q),
    .op2    (alu_op2),
    .sel    (alu_sel),
    .shamt  (shamt),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    zero_d  = zero_q;
    regs_d  = regs_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = (rs == 5'd0) ? 32'd0 : regs_q[rs];
        b_d     = (rt == 5'd0) ? 32'd0 : regs_q[rt];
        state_d = EXEC;
      end
      EXEC: begin
        alu_d  = alu_res;
        zero_d = alu_zero;
        if (is_ill)                   state_d = SKIP_ILLEGAL ? WB : HALT;
        else if (is_load || is_store) state_d = MEM;
        else                          state_d = WB;
      end
      MEM: begin
        if (bus.dmem_ready) begin
          if (is_load) mdr_d = bus.dmem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        if (wr_en && (wr_addr != 5'd0)) regs_d[wr_addr] = is_load ? mdr_q : alu_q;
        if ((is_beq && zero_q) || (is_bne && !zero_q)) pc_d = br_target;
        else if (is_j)                                  pc_d = j_target;
        else if (is_jr)                                 pc_d = a_q;
        else                                            pc_d = pc_plus4;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      zero_q  <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[29] <= SP_INIT;
      regs_q[31] <= RA_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      zero_q  <= zero_d;
      regs_q  <= regs_d;
    end
  end

  // The reset gate keeps imem_req low while reset is held, even though the state sits in FETCH.
  assign bus.imem_req   = (state_q == FETCH) && reset;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == MEM);
  assign bus.dmem_we    = (state_q == MEM) && is_store;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = b_q;

  assign retire  = (state_q == WB) && !is_ill;
  assign illegal = (state_q == EXEC) && is_ill;
  assign halted  = (state_q == HALT);
  assign pc      = pc_q;

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed program bench for mips_mc_core: skip-mode core running a short program, plus a halt-mode core.
module tb_mips_mc_core;

  logic clk;
  logic reset;
  logic reset2;
  logic retire, illegal, halted;
  logic retire2, illegal2, halted2;
  logic [31:0] pc, pc2;

  mips_mc_core_if bus1();
  mips_mc_core_if bus2();

  mips_mc_core #(.PC_INIT(32'h0), .SP_INIT(32'h0), .RA_INIT(32'h80), .SKIP_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus1), .retire(retire), .illegal(illegal), .halted(halted), .pc(pc)
  );

  mips_mc_core #(.PC_INIT(32'h0), .SP_INIT(32'h0), .RA_INIT(32'h0), .SKIP_ILLEGAL(1'b0)) u_dut_halt (
    .clk(clk), .reset(reset2), .bus(bus2), .retire(retire2), .illegal(illegal2), .halted(halted2), .pc(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [256] = '{default: '0};
  int dmem_wait = 3;
  int dcnt = 0;

  assign bus1.imem_ready = bus1.imem_req;
  assign bus1.imem_rdata = imem[bus1.imem_addr[9:2]];
  assign bus1.dmem_ready = bus1.dmem_req && (dcnt >= dmem_wait);
  assign bus1.dmem_rdata = dmem[bus1.dmem_addr[9:2]];

  assign bus2.imem_ready = bus2.imem_req;
  assign bus2.imem_rdata = 32'hFC00_0000;
  assign bus2.dmem_ready = 1'b0;
  assign bus2.dmem_rdata = 32'h0;

  always @(posedge clk) begin
    if (bus1.dmem_req && !bus1.dmem_ready) dcnt <= dcnt + 1;
    else                                    dcnt <= 0;
  end

  int checks = 0, failures = 0;
  int cyc = 0, ret_cnt = 0, ill_cnt = 0, fetch_cnt = 0, st_cnt = 0;
  int we_cnt = 0, rd_cnt = 0, both_cnt = 0, ill2_cnt = 0, bad2 = 0;
  int ret_cyc [64];
  logic [31:0] last_fetch = '0, st_addr = '0, st_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (retire) begin
      if (ret_cnt < 64) ret_cyc[ret_cnt] = cyc;
      ret_cnt++;
    end
    if (illegal) ill_cnt++;
    if (bus1.imem_req && bus1.imem_ready) begin
      last_fetch = bus1.imem_addr;
      fetch_cnt++;
    end
    if (bus1.dmem_req && bus1.dmem_we && bus1.dmem_ready) begin
      dmem[bus1.dmem_addr[9:2]] = bus1.dmem_wdata;
      st_addr = bus1.dmem_addr;
      st_data = bus1.dmem_wdata;
      st_cnt++;
    end
    if (bus1.dmem_req) begin
      if (bus1.dmem_we) we_cnt++;
      else              rd_cnt++;
    end
    if (bus1.imem_req && bus1.dmem_req) both_cnt++;
    if (illegal2) ill2_cnt++;
    if (halted2 && bus2.imem_req) bad2++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sel: 0 retire count, 1 fetch count, 2 store count, 3 illegal count
  task automatic wait_evt(input string tag, input int sel, input int n);
    int k;
    int cur;
    k = 0;
    cur = 0;
    while (k < 300) begin
      case (sel)
        0: cur = ret_cnt;
        1: cur = fetch_cnt;
        2: cur = st_cnt;
        default: cur = ill_cnt;
      endcase
      if (cur >= n) break;
      tick();
      k++;
    end
    check(tag, 32'(cur >= n), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]  = 32'h2408_0005; // addiu $8,$0,5
    imem[1]  = 32'h0108_4821; // addu  $9,$8,$8
    imem[2]  = 32'hAC09_0100; // sw    $9,0x100($0)
    imem[3]  = 32'h8C0A_0100; // lw    $10,0x100($0)
    imem[4]  = 32'hAC0A_0104; // sw    $10,0x104($0)
    imem[5]  = 32'h2400_0007; // addiu $0,$0,7
    imem[6]  = 32'h0000_0821; // addu  $1,$0,$0
    imem[7]  = 32'hAC01_0108; // sw    $1,0x108($0)
    imem[8]  = 32'h1108_FFFF; // beq   $8,$8,-1
    imem[9]  = 32'h0800_0040; // j     0x40
    imem[64] = 32'h3C02_8000; // lui   $2,0x8000
    imem[65] = 32'h0040_182A; // slt   $3,$2,$0
    imem[66] = 32'hAC03_010C; // sw    $3,0x10C($0)
    imem[67] = 32'h03E0_0008; // jr    $31
    imem[32] = 32'hFC00_0000; // undecodable
    imem[33] = 32'h0009_20C0; // sll   $4,$9,3
    imem[34] = 32'hAC04_0110; // sw    $4,0x110($0)
    imem[35] = 32'h0109_2823; // subu  $5,$8,$9
    imem[36] = 32'h0109_3025; // or    $6,$8,$9
    imem[37] = 32'hAC05_0114; // sw    $5,0x114($0)
    imem[38] = 32'hAC06_0118; // sw    $6,0x118($0)
    imem[39] = 32'hAC09_011C; // sw    $9,0x11C($0)

    reset  = 1'b0;
    reset2 = 1'b0;
    tick();
    tick();
    check("rst_imem_req", 32'(bus1.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus1.dmem_req), 32'd0);
    check("rst_dmem_we",  32'(bus1.dmem_we), 32'd0);
    check("rst_flags",    {29'd0, retire, illegal, halted}, 32'd0);
    check("rst_pc",       pc, 32'h0);

    reset  = 1'b1;
    reset2 = 1'b1;
    #1;
    check("rel_imem_req",  32'(bus1.imem_req), 32'd1);
    check("rel_imem_addr", bus1.imem_addr, 32'h0);

    wait_evt("wait_addu", 0, 2);
    check("addu_gap", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    wait_evt("wait_st1", 2, 1);
    check("st1_addr", st_addr, 32'h100);
    check("st1_data", st_data, 32'd10);
    wait_evt("wait_lw", 0, 4);
    check("lw_latency", 32'(ret_cyc[3] - ret_cyc[2]), 32'd8);
    check("we_cycles", 32'(we_cnt), 32'd4);
    check("rd_cycles", 32'(rd_cnt), 32'd4);
    dmem_wait = 0;
    wait_evt("wait_st2", 2, 2);
    check("lw_value", st_data, 32'd10);
    wait_evt("wait_st3", 2, 3);
    check("r0_sum", st_data, 32'd0);

    wait_evt("wait_beq", 0, 9);
    imem[8] = 32'h1508_FFFF; // bne $8,$8,-1 replaces the taken beq
    wait_evt("wait_f_beq", 1, fetch_cnt + 1);
    check("beq_target", last_fetch, 32'h20);
    wait_evt("wait_bne", 0, 10);
    wait_evt("wait_f_bne", 1, fetch_cnt + 1);
    check("bne_target", last_fetch, 32'h24);
    wait_evt("wait_j", 0, 11);
    wait_evt("wait_f_j", 1, fetch_cnt + 1);
    check("j_target", last_fetch, 32'h100);

    wait_evt("wait_st4", 2, 4);
    check("slt_value", st_data, 32'd1);
    wait_evt("wait_jr", 0, 15);
    wait_evt("wait_f_jr", 1, fetch_cnt + 1);
    check("jr_target", last_fetch, 32'h80);

    wait_evt("wait_ill", 3, 1);
    wait_evt("wait_f_ill", 1, fetch_cnt + 1);
    check("ill_next_pc", last_fetch, 32'h84);
    check("ill_no_retire", 32'(ret_cnt), 32'd15);
    check("ill_pulses", 32'(ill_cnt), 32'd1);

    wait_evt("wait_st5", 2, 5);
    check("sll_value", st_data, 32'd80);
    wait_evt("wait_st6", 2, 6);
    check("subu_value", st_data, 32'hFFFF_FFFB);
    wait_evt("wait_st7", 2, 7);
    check("or_value", st_data, 32'd15);
    check("st7_addr", st_addr, 32'h118);

    dmem_wait = 20;
    for (int k = 0; k < 40 && !bus1.dmem_req; k++) tick();
    check("mem_reached", 32'(bus1.dmem_req && bus1.dmem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mem_req", 32'(bus1.dmem_req), 32'd0);
    check("rst_mem_imem", 32'(bus1.imem_req), 32'd0);
    tick();
    tick();
    check("rst_no_store", 32'(st_cnt), 32'd7);
    check("rst_last_addr", st_addr, 32'h118);
    reset = 1'b1;
    #1;
    check("rel2_imem_req", 32'(bus1.imem_req), 32'd1);
    check("rel2_imem_addr", bus1.imem_addr, 32'h0);
    tick();
    tick();

    check("halt_level", 32'(halted2), 32'd1);
    check("halt_imem_req", 32'(bus2.imem_req), 32'd0);
    check("halt_dmem_req", 32'(bus2.dmem_req), 32'd0);
    check("halt_no_req", 32'(bad2), 32'd0);
    check("halt_ill_pulse", 32'(ill2_cnt), 32'd1);
    check("halt_no_retire", 32'(retire2), 32'd0);
    check("req_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 The block SHALL have parameter PC_INIT, default 32'h0000_0000, meaning the fetch address after reset.
REQ-002 The block SHALL have parameter SP_INIT, default 32'h0000_0000, meaning the $29 value after reset.
REQ-003 The block SHALL have parameter RA_INIT, default 32'h0000_0000, meaning the $31 value after reset.
REQ-004 The block SHALL have parameter SKIP_ILLEGAL, default 1, meaning 1 = skip undecodable instructions, 0 = halt on them.
REQ-005 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  instruction read request.
REQ-008 imem_addr  out  32  instruction word address.
REQ-009 imem_ready  in  1  instruction data valid.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 dmem_req  out  1  data access request.
REQ-012 dmem_we  out  1  1 = store, 0 = load.
REQ-013 dmem_addr  out  32  data byte address.
REQ-014 dmem_wdata  out  32  store data.
REQ-015 dmem_ready  in  1  data access complete; load data valid.
REQ-016 dmem_rdata  in  32  load data.
REQ-017 retire  out  1  one-cycle pulse per completed instruction.
REQ-018 illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-019 halted  out  1  level; core is stopped.
REQ-020 pc  out  32  architectural PC.

Function
REQ-021 The FSM SHALL use states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-022 FETCH: imem_req=1 and imem_addr=pc are held until imem_ready; the instruction is latched and the FSM goes to DECODE; the FSM waits in FETCH with no timeout.
REQ-023 DECODE: rs/rt are read from a 32x32 register file into A/B, with $0 reading as 0, and the FSM goes to EXEC.
REQ-024 EXEC: the ALU result is latched; lw/sw go to MEM; every other instruction goes to WB.
REQ-025 MEM: dmem_req=1, dmem_addr=ALU result and dmem_wdata=B are held until dmem_ready; dmem_we=1 only for sw; load data is latched on dmem_ready; the FSM then goes to WB.
REQ-026 WB: the register write and the PC update happen and retire pulses; the FSM goes to FETCH.
REQ-027 Minimum latency SHALL be 4 cycles for non-memory instructions and 5 cycles for lw/sw, with each wait cycle on the ready inputs adding one cycle.
REQ-028 R-type instructions (opcode 0) SHALL be supported with funct 21 addu, 23 subu, 24 and, 25 or, 2A slt (signed), 00 sll (shamt), and 08 jr.
REQ-029 I/J-type instructions SHALL be supported with opcode 09 addiu, 0F lui, 23 lw, 2B sw, 04 beq, 05 bne, and 02 j.
REQ-030 Immediates SHALL be sign-extended for addiu/lw/sw/beq/bne; lui SHALL produce {imm,16'h0}.
REQ-031 Arithmetic SHALL be modulo 2^32 and SHALL never trap.
REQ-032 Destination SHALL be rd for R-type and rt for addiu/lui/lw; sw/beq/bne/j/jr write nothing; writes to $0 are discarded.
REQ-033 Next PC SHALL be one of: pc+4 by default; pc+4+(simm<<2) for a taken branch; {pc_plus4[31:28],target,2'b00} for j; A for jr.
REQ-034 Any other opcode/funct SHALL pulse illegal in EXEC.
REQ-035 With SKIP_ILLEGAL=1, an illegal instruction SHALL go to WB with no register write, pc+4 and retire=0.
REQ-036 With SKIP_ILLEGAL=0, an illegal instruction SHALL go to HALT, where halted=1, the FSM stays until reset, and no request is issued.
REQ-037 imem_req and dmem_req SHALL never be asserted in the same cycle.

Reset
REQ-038 While reset=0 the block SHALL set: state=FETCH; pc=PC_INIT; $29=SP_INIT; $31=RA_INIT; all other registers 0; imem_req, dmem_req, dmem_we, retire, illegal and halted all 0.
REQ-039 Reset asserted mid-FETCH or mid-MEM SHALL drop the request immediately and perform no register or memory side effect.
REQ-040 In the first cycle after reset release the block SHALL assert imem_req with imem_addr=PC_INIT.

Structure
REQ-041 The opcode/funct constants and the state enum SHALL live in the shared package mips_pkg.
REQ-042 The ALU SHALL be the sub-module mips_mc_alu (combinational; op1, op2, sel, shamt -> result, zero).
REQ-043 The register file SHALL be inside mips_mc_core.

Verification
REQ-044 addiu $8,$0,5 then addu $9,$8,$8 with zero-wait memories -> $9=10 and retire pulses 4 cycles apart.
REQ-045 sw $9,0x100($0) then lw $10,0x100($0) with dmem_ready delayed 3 cycles -> dmem_we=1 only on the store, $10=10, and lw latency=8.
REQ-046 beq $8,$8,-1 at PC 0x20 -> next fetch 0x20; bne equal -> next fetch 0x24; j 0x40 -> 0x100; jr $31 (RA_INIT=0x80) -> 0x80.
REQ-047 Opcode 3F with SKIP_ILLEGAL=1 -> illegal pulse, no retire, next fetch pc+4; with SKIP_ILLEGAL=0 -> halted=1 and no further imem_req.
REQ-048 reset driven low while dmem_req=1 for sw -> dmem_req=0 in the same cycle, memory not written, and after release imem_addr=PC_INIT.
REQ-049 addiu $0,$0,7 then addu $1,$0,$0 -> $1=0; lui $2,0x8000 then slt $3,$2,$0 -> $3=1.
